// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: func3 codes, FSM encoding, requester ids.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_pkg;

    // RISC-V load/store size/sign codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Arbiter FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DMA  = 1'b1
    } req_id_t;

    // Access size in bytes implied by func3; func3[2] only selects sign handling.
    function automatic logic [2:0] access_size(input logic [2:0] func3);
        case (func3[1:0])
            2'b00:   access_size = 3'd1;
            2'b01:   access_size = 3'd2;
            default: access_size = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_check.sv
// Legality check for one memory access: legal func3 for the direction, natural alignment, in range.
// Latency: purely combinational.
// Backpressure: none; evaluated on whatever request the arbiter presents.
//
// Ports: we (1 = store), func3 (size/sign code), addr (byte address) -> ok (access may touch memory).
module dmem_access_check
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 32
) (
    input  logic              we,
    input  logic [2:0]        func3,
    input  logic [ADDR_W-1:0] addr,
    output logic              ok
);

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_BYTES);

    logic            legal;
    logic            aligned;
    logic            in_range;
    logic [ADDR_W:0] size_ext;
    logic [ADDR_W:0] end_addr;

    always_comb begin
        case (func3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = ~we;   // unsigned variants exist only for loads
            default:          legal = 1'b0;
        endcase

        case (func3[1:0])
            2'b01:   aligned = ~addr[0];
            2'b10:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase

        // One extra bit so an address near the top of the space cannot wrap into range.
        size_ext = {{(ADDR_W-2){1'b0}}, access_size(func3)};
        end_addr = {1'b0, addr} + size_ext;
        in_range = (end_addr <= LIMIT);

        ok = legal & aligned & in_range;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-ported data memory between the core MEM stage and a DMA port.
// Latency: req seen in cycle 0, memory strobe in cycle 1, one-cycle ack in cycle 2; accesses 3 cycles apart.
// Backpressure: requester holds req and fields until its ack; the other port simply waits in IDLE.
//
// Ports: clk/reset; core_* and dma_* request ports (req/we/func3/addr/wdata in, rdata/ack/err out);
//        mem_* drive the memory (address, write_data, memRead, memWrite, func3) and mem_read_data returns
//        its combinational load data.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [2:0]        core_func3,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_ack,
    output logic              core_err,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [2:0]        dma_func3,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic              dma_err,

    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_memRead,
    output logic              mem_memWrite,
    output logic [2:0]        mem_func3,
    input  logic [DATA_W-1:0] mem_read_data
);

    logic [1:0]        state;
    req_id_t           last_grant;
    req_id_t           lat_id;
    logic              lat_we;
    logic              lat_ok;

    req_id_t           pick;
    logic              any_req;
    logic              sel_we;
    logic [2:0]        sel_func3;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_ok;
    logic [DATA_W-1:0] load_dat;

    // Winner selection: a lone request wins outright; on a tie the port not granted last time wins.
    always_comb begin
        any_req = core_req | dma_req;
        pick    = REQ_CORE;
        if (core_req && dma_req) begin
            pick = (last_grant == REQ_CORE) ? REQ_DMA : REQ_CORE;
        end else if (dma_req) begin
            pick = REQ_DMA;
        end
    end

    assign sel_we    = (pick == REQ_DMA) ? dma_we     : core_we;
    assign sel_func3 = (pick == REQ_DMA) ? dma_func3  : core_func3;
    assign sel_addr  = (pick == REQ_DMA) ? dma_addr   : core_addr;
    assign sel_wdata = (pick == REQ_DMA) ? dma_wdata  : core_wdata;

    dmem_access_check #(
        .ADDR_W    (ADDR_W),
        .MEM_BYTES (MEM_BYTES)
    ) u_check (
        .we    (sel_we),
        .func3 (sel_func3),
        .addr  (sel_addr),
        .ok    (sel_ok)
    );

    // Stores and rejected accesses return zero rather than whatever the memory port shows.
    assign load_dat = (lat_we || !lat_ok) ? '0 : mem_read_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            last_grant     <= REQ_DMA;   // core wins the first tie
            lat_id         <= REQ_CORE;
            lat_we         <= 1'b0;
            lat_ok         <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_memRead    <= 1'b0;
            mem_memWrite   <= 1'b0;
            mem_func3      <= '0;
            core_rdata     <= '0;
            core_ack       <= 1'b0;
            core_err       <= 1'b0;
            dma_rdata      <= '0;
            dma_ack        <= 1'b0;
            dma_err        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        // The mem_* registers double as the latched address/data/func3.
                        lat_id         <= pick;
                        lat_we         <= sel_we;
                        lat_ok         <= sel_ok;
                        last_grant     <= pick;
                        mem_address    <= sel_addr;
                        mem_write_data <= sel_wdata;
                        mem_func3      <= sel_func3;
                        mem_memWrite   <= sel_we & sel_ok;
                        mem_memRead    <= ~sel_we & sel_ok;
                        state          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mem_memRead  <= 1'b0;
                    mem_memWrite <= 1'b0;
                    if (lat_id == REQ_CORE) begin
                        core_rdata <= load_dat;
                        core_err   <= ~lat_ok;
                        core_ack   <= 1'b1;
                    end else begin
                        dma_rdata <= load_dat;
                        dma_err   <= ~lat_ok;
                        dma_ack   <= 1'b1;
                    end
                    state <= ST_ACK;
                end
                ST_ACK: begin
                    core_ack <= 1'b0;
                    dma_ack  <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    mem_memRead  <= 1'b0;
                    mem_memWrite <= 1'b0;
                    core_ack     <= 1'b0;
                    dma_ack      <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported data memory between two requesters: the pipeline MEM stage (core port) and a loader/debug DMA port.
- Sits between those requesters and the data memory. Drives the memory's address, write_data, memRead, memWrite and func3 inputs, and returns its combinational read_data.
- Sequences each access through a fixed 3-cycle handshake with round-robin fairness.
- Rejects misaligned, out-of-range and illegal-size accesses without touching memory.

Parameters:
- ADDR_W, 32, address width of requests and memory port.
- DATA_W, 32, data width (fixed 32; byte/half/word selected by func3).
- MEM_BYTES, 32, number of bytes in the data memory; used for the range check.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- core_req  in  1  core access request; held with its fields until core_ack.
- core_we  in  1  1 = store, 0 = load.
- core_func3  in  3  RISC-V load/store func3 size/sign code.
- core_addr  in  ADDR_W  byte address.
- core_wdata  in  DATA_W  store data, low bytes used.
- core_rdata  out  DATA_W  load result; valid with core_ack.
- core_ack  out  1  one-cycle completion pulse.
- core_err  out  1  valid with core_ack; access rejected.
- dma_req, dma_we, dma_func3, dma_addr, dma_wdata, dma_rdata, dma_ack, dma_err: identical set for the DMA port.
- mem_address  out  ADDR_W  to memory address.
- mem_write_data  out  DATA_W  to memory write_data.
- mem_memRead  out  1  memory read strobe.
- mem_memWrite  out  1  memory write strobe.
- mem_func3  out  3  to memory func3.
- mem_read_data  in  DATA_W  combinational memory read data.

Behaviour:
- Reset (asynchronous, immediate): state = IDLE; all mem_* outputs, *_rdata, *_ack and *_err = 0; last_grant = DMA, so the core wins the first tie. A transaction in flight is abandoned and the requester must reissue.
- FSM states: IDLE, ISSUE, ACK.
- IDLE:
  - No request: stay in IDLE, strobes 0.
  - One request: grant it.
  - Both requests: grant the port not in last_grant.
  - On the granting edge: latch the winner's id, we, func3, addr, wdata and the check result; update last_grant; go to ISSUE.
- ISSUE (exactly one cycle):
  - mem_* outputs are registered from the latched request.
  - mem_memWrite = we & ok; mem_memRead = !we & ok. Both are 0 when the check failed.
  - On the next edge: capture mem_read_data into the winner's rdata (loads only, else 0); set the winner's err = !ok; go to ACK.
- ACK (exactly one cycle):
  - Winner's ack = 1; strobes = 0; next state IDLE.
  - The requester drops or changes req after seeing ack. Req sampled in IDLE on the following edge starts a new access.
- Latency: req high in cycle 0 → strobe in cycle 1 → ack in cycle 2. Minimum spacing between accesses is 3 cycles.
- *_rdata and *_err hold until that port's next ack. The loser's outputs never change.
- Check (ok = legal & aligned & in_range):
  - Legal loads: func3 000, 001, 010, 100, 101. Legal stores: 000, 001, 010. Anything else is illegal.
  - size = 1/2/4 bytes. Aligned: half → addr[0]=0; word → addr[1:0]=0.
  - in_range: addr + size ≤ MEM_BYTES, computed in ADDR_W+1 bits so wrap cannot pass.
- Request changing during ISSUE/ACK has no effect; only latched values are used.
- Starvation bound: a continuously asserted request is acked within 6 cycles.

Decomposition:
- Shared package dmem_pkg:
  - func3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - FSM state encoding (IDLE/ISSUE/ACK).
  - Requester id enum (REQ_CORE, REQ_DMA).
- One sub-module: dmem_access_check. Combinational; inputs we, func3, addr; output ok; parameter MEM_BYTES. Instantiated once on the muxed winner request.

Test Plan:
- Core only: store word func3=010, addr 0x08, wdata 0xDEADBEEF, then load word 0x08. → mem_memWrite high in cycle 1; core_ack in cycle 2 with core_err=0; load returns core_rdata=0xDEADBEEF.
- Simultaneous core and DMA loads from reset, held high. → Core acked in cycle 2, DMA in cycle 5, core again in cycle 8 (alternation).
- Misaligned core load half func3=001, addr 0x03. → No mem strobe in any cycle; core_ack with core_err=1, core_rdata=0.
- Out of range: DMA load word at addr 0x1E with MEM_BYTES=32. → dma_err=1, no strobe. Word at 0x1C succeeds with dma_err=0.
- Illegal: core store func3=100. → core_err=1, mem_memWrite stays 0. Core load func3=011 → core_err=1.
- Reset asserted during ISSUE cycle. → Strobes drop to 0 before the next edge, no ack issued; after release the FSM is in IDLE and a tie goes to core.
